// File: rtl/morse_pkg.sv
// morse_pkg: shared Morse encodings for the symbol collector and ROM compare stage
package morse_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, HOLD = 2'd2} state_t;
  localparam logic SYM_DOT = 1'b0;
  localparam logic SYM_DASH = 1'b1;
  localparam int DEF_MAX_LEN = 5;
  localparam int LEN_W = 3;
endpackage

// File: rtl/morse_gap_timer.sv
// morse_gap_timer: saturating idle counter with a one-cycle expire flag
module morse_gap_timer #(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int CNT_W = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
  assign expire = en && !clear && cnt == LAST;
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (en && cnt != LAST) cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/morse_symbol_collector.sv
// morse_symbol_collector: gathers dot/dash pulses into one Morse character with valid/ack handoff
module morse_symbol_collector
  import morse_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int CNT_W = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dot_pulse,
  input  logic               dash_pulse,
  input  logic               submit_pulse,
  input  logic               clear_pulse,
  output logic [MAX_LEN-1:0] code_out,
  output logic [LEN_W-1:0]   len_out,
  output logic               code_valid,
  input  logic               code_ack,
  output logic               overflow
);
  state_t state, state_d;
  logic [MAX_LEN-1:0] code_q, code_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic valid_q, valid_d, ovf_q, ovf_d;
  logic sym_ev, sym_bit, full, close, accept, append, expire, t_clear, t_en;
  assign sym_ev = dot_pulse ^ dash_pulse;
  assign sym_bit = dash_pulse ? SYM_DASH : SYM_DOT;
  assign full = len_q == LEN_W'(MAX_LEN);
  assign close = (state == COLLECT && (submit_pulse || expire)) || (state == IDLE && sym_ev && submit_pulse);
  assign accept = state == HOLD && valid_q && code_ack;
  assign append = sym_ev && state != HOLD && !full;
  assign t_en = state == COLLECT && !(dot_pulse && dash_pulse);
  assign t_clear = clear_pulse || sym_ev || state != COLLECT;
  morse_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .clear(t_clear),
    .en(t_en),
    .expire(expire)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      code_q <= '0;
      len_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_d;
      code_q <= code_d;
      len_q <= len_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
    end
  end
  always_comb begin
    state_d = clear_pulse ? IDLE :
              close ? HOLD :
              (state == IDLE && sym_ev) ? COLLECT :
              accept ? IDLE : state;
  end
  always_comb begin
    code_d = code_q;
    len_d = len_q;
    valid_d = valid_q;
    ovf_d = ovf_q;
    if (clear_pulse || accept) begin
      code_d = '0;
      len_d = '0;
      valid_d = 1'b0;
      ovf_d = 1'b0;
    end else begin
      if (append) begin
        code_d = code_q | (MAX_LEN'(sym_bit) << len_q);
        len_d = len_q + LEN_W'(1);
      end
      if (sym_ev && state == COLLECT && full) ovf_d = 1'b1;
      if (close) valid_d = 1'b1;
    end
  end
  assign code_out = code_q;
  assign len_out = len_q;
  assign code_valid = valid_q;
  assign overflow = ovf_q;
endmodule
